execute_stage: RTL and testbench

- Execute (EX) stage of the 16-bit pipelined CPU, between the decode/register-read stage and the memory stage.
- Decodes a 4-bit opcode and performs ALU, shift, compare, jump-target and address computations.
- Holds the ZF/GF/LF condition flags.
- Registers all results into the EX/MEM pipeline outputs with one-cycle latency.

---
 rtl/execute_stage_if.sv | 36 +++
 rtl/execute_stage.sv | 116 +++++++++++
 tb/tb_execute_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// EX-stage bus: decoded operands in from register-read, registered results out to memory stage.
// Latency: n/a (wiring only).
// Backpressure: none; one instruction per cycle.
interface execute_stage_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 7
);
    logic [4:0]        control_in;
    logic [4:0]        dest_index_in;
    logic [DATA_W-1:0] reg1_data;
    logic [DATA_W-1:0] reg2_data;
    logic [DATA_W-1:0] npc;
    logic [IMM_W-1:0]  immediate;

    logic [4:0]        dest_index_out;
    logic [4:0]        control_out;
    logic [DATA_W-1:0] output_reg;
    logic [DATA_W-1:0] result_out;
    logic [DATA_W-1:0] target;
    logic              DEST_REG_WRITE_EN;
    logic              ZF;
    logic              GF;
    logic              LF;

    modport master (
        output control_in, dest_index_in, reg1_data, reg2_data, npc, immediate,
        input  dest_index_out, control_out, output_reg, result_out, target,
               DEST_REG_WRITE_EN, ZF, GF, LF
    );

    modport slave (
        input  control_in, dest_index_in, reg1_data, reg2_data, npc, immediate,
        output dest_index_out, control_out, output_reg, result_out, target,
               DEST_REG_WRITE_EN, ZF, GF, LF
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU/shift/compare/branch-target/address generation plus ZF/GF/LF flags.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; accepts a new instruction every cycle.
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 7
) (
    input  logic            clk,
    input  logic            reset,
    execute_stage_if.slave  ex
);

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_SUB    = 4'd1,
        OP_ADD    = 4'd2,
        OP_ADDI   = 4'd3,
        OP_SHLLI  = 4'd4,
        OP_SHRLI  = 4'd5,
        OP_JUMP   = 4'd6,
        OP_JUMPL  = 4'd7,
        OP_JUMPG  = 4'd8,
        OP_JUMPE  = 4'd9,
        OP_JUMPNE = 4'd10,
        OP_CMP    = 4'd11,
        OP_LOAD   = 4'd12,
        OP_LOADI  = 4'd13,
        OP_STORE  = 4'd14,
        OP_MOV    = 4'd15
    } op_e;

    op_e               opcode;
    logic              reserved_nop;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;
    logic [3:0]        shamt;

    logic [DATA_W-1:0] result_nxt;
    logic [DATA_W-1:0] target_nxt;
    logic              we_nxt;
    logic              taken;
    logic              flags_we;
    logic              zf_nxt;
    logic              gf_nxt;
    logic              lf_nxt;

    assign opcode       = op_e'(ex.control_in[3:0]);
    assign reserved_nop = ex.control_in[4];
    assign simm         = {{(DATA_W-IMM_W){ex.immediate[IMM_W-1]}}, ex.immediate};
    assign zimm         = {{(DATA_W-IMM_W){1'b0}}, ex.immediate};
    assign shamt        = ex.immediate[3:0];

    always_comb begin
        result_nxt = '0;
        we_nxt     = 1'b0;
        taken      = 1'b0;
        flags_we   = 1'b0;
        zf_nxt     = ex.ZF;
        gf_nxt     = ex.GF;
        lf_nxt     = ex.LF;
        if (!reserved_nop) begin
            unique case (opcode)
                OP_SUB:    begin result_nxt = ex.reg1_data - ex.reg2_data; we_nxt = 1'b1; end
                OP_ADD:    begin result_nxt = ex.reg1_data + ex.reg2_data; we_nxt = 1'b1; end
                OP_ADDI:   begin result_nxt = ex.reg1_data + simm;         we_nxt = 1'b1; end
                OP_SHLLI:  begin result_nxt = ex.reg1_data << shamt;       we_nxt = 1'b1; end
                OP_SHRLI:  begin result_nxt = ex.reg1_data >> shamt;       we_nxt = 1'b1; end
                OP_LOAD:   begin result_nxt = ex.reg1_data + simm;         we_nxt = 1'b1; end
                OP_LOADI:  begin result_nxt = zimm;                        we_nxt = 1'b1; end
                OP_STORE:  result_nxt = ex.reg1_data + simm;
                OP_MOV:    begin result_nxt = ex.reg2_data;                we_nxt = 1'b1; end
                // Branches see the flags as registered before this edge.
                OP_JUMP:   taken = 1'b1;
                OP_JUMPL:  taken = ex.LF;
                OP_JUMPG:  taken = ex.GF;
                OP_JUMPE:  taken = ex.ZF;
                OP_JUMPNE: taken = !ex.ZF;
                OP_CMP: begin
                    flags_we = 1'b1;
                    zf_nxt   = (ex.reg1_data == ex.reg2_data);
                    gf_nxt   = (ex.reg1_data >  ex.reg2_data);
                    lf_nxt   = (ex.reg1_data <  ex.reg2_data);
                end
                default: ;
            endcase
        end
        target_nxt = taken ? (ex.npc + simm) : ex.npc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex.dest_index_out    <= '0;
            ex.control_out       <= '0;
            ex.output_reg        <= '0;
            ex.result_out        <= '0;
            ex.target            <= '0;
            ex.DEST_REG_WRITE_EN <= 1'b0;
            ex.ZF                <= 1'b0;
            ex.GF                <= 1'b0;
            ex.LF                <= 1'b0;
        end else begin
            ex.dest_index_out    <= ex.dest_index_in;
            ex.control_out       <= ex.control_in;
            ex.output_reg        <= ex.reg2_data;
            ex.result_out        <= result_nxt;
            ex.target            <= target_nxt;
            ex.DEST_REG_WRITE_EN <= we_nxt;
            if (flags_we) begin
                ex.ZF <= zf_nxt;
                ex.GF <= gf_nxt;
                ex.LF <= lf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed table-driven bench for execute_stage plus hand-written reset/flag sequences.
module tb_execute_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_stage_if #(.DATA_W(16), .IMM_W(7)) bus ();

    execute_stage #(.DATA_W(16), .IMM_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    typedef struct {
        logic [4:0]  ctrl;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] npc;
        logic [6:0]  imm;
        logic [15:0] res;
        logic        we;
        logic [15:0] tgt;
        logic [2:0]  flg;   // {ZF, GF, LF}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic [4:0] ctrl, input logic [15:0] r1, input logic [15:0] r2,
                                input logic [15:0] npc, input logic [6:0] imm, input logic [15:0] res,
                                input logic we, input logic [15:0] tgt, input logic [2:0] flg);
        vec_t v;
        v.ctrl = ctrl; v.r1 = r1; v.r2 = r2; v.npc = npc; v.imm = imm;
        v.res = res; v.we = we; v.tgt = tgt; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctrl, input logic [15:0] r1, input logic [15:0] r2,
                         input logic [15:0] npc, input logic [6:0] imm, input logic [4:0] dest);
        bus.control_in    = ctrl;
        bus.reg1_data     = r1;
        bus.reg2_data     = r2;
        bus.npc           = npc;
        bus.immediate     = imm;
        bus.dest_index_in = dest;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] ctrl, input logic [4:0] dest,
                           input logic [15:0] r2, input logic [15:0] res, input logic we,
                           input logic [15:0] tgt, input logic [2:0] flg);
        chk({tag, ".result"},  bus.result_out, res);
        chk({tag, ".we"},      16'(bus.DEST_REG_WRITE_EN), 16'(we));
        chk({tag, ".target"},  bus.target, tgt);
        chk({tag, ".flags"},   16'({bus.ZF, bus.GF, bus.LF}), 16'(flg));
        chk({tag, ".ctrl"},    16'(bus.control_out), 16'(ctrl));
        chk({tag, ".dest"},    16'(bus.dest_index_out), 16'(dest));
        chk({tag, ".outreg"},  bus.output_reg, r2);
    endtask

    initial begin
        // ctrl, r1, r2, npc, imm, res, we, target, {Z,G,L}
        vecs.push_back(mk(5'd0,  16'd5,     16'd6,  16'd9,  7'd3,   16'd0,  1'b0, 16'd9,  3'b000)); // NOP
        vecs.push_back(mk(5'd1,  16'd10,    16'd3,  16'd1,  7'd0,   16'd7,  1'b1, 16'd1,  3'b000)); // SUB
        vecs.push_back(mk(5'd2,  16'd10,    16'd5,  16'd2,  7'd0,   16'd15, 1'b1, 16'd2,  3'b000)); // ADD
        vecs.push_back(mk(5'd3,  16'd10,    16'd0,  16'd3,  7'd7,   16'd17, 1'b1, 16'd3,  3'b000)); // ADDI
        vecs.push_back(mk(5'd3,  16'd10,    16'd0,  16'd4,  7'h7F,  16'd9,  1'b1, 16'd4,  3'b000)); // ADDI -1
        vecs.push_back(mk(5'd2,  16'hFFFF,  16'd1,  16'd5,  7'd0,   16'd0,  1'b1, 16'd5,  3'b000)); // ADD wrap
        vecs.push_back(mk(5'd4,  16'd8,     16'd0,  16'd6,  7'd1,   16'd16, 1'b1, 16'd6,  3'b000)); // SHLLI
        vecs.push_back(mk(5'd5,  16'd8,     16'd0,  16'd7,  7'd1,   16'd4,  1'b1, 16'd7,  3'b000)); // SHRLI
        vecs.push_back(mk(5'd5,  16'h8000,  16'd0,  16'd8,  7'd15,  16'd1,  1'b1, 16'd8,  3'b000)); // SHRLI 15
        vecs.push_back(mk(5'd6,  16'd0,     16'd0,  16'd5,  7'd1,   16'd0,  1'b0, 16'd6,  3'b000)); // JUMP
        vecs.push_back(mk(5'd11, 16'd4,     16'd8,  16'd0,  7'd1,   16'd0,  1'b0, 16'd0,  3'b001)); // CMP lt
        vecs.push_back(mk(5'd7,  16'd0,     16'd0,  16'd0,  7'd1,   16'd0,  1'b0, 16'd1,  3'b001)); // JUMPL taken
        vecs.push_back(mk(5'd11, 16'd8,     16'd4,  16'd0,  7'd1,   16'd0,  1'b0, 16'd0,  3'b010)); // CMP gt
        vecs.push_back(mk(5'd8,  16'd0,     16'd0,  16'd0,  7'd1,   16'd0,  1'b0, 16'd1,  3'b010)); // JUMPG taken
        vecs.push_back(mk(5'd7,  16'd0,     16'd0,  16'd3,  7'd1,   16'd0,  1'b0, 16'd3,  3'b010)); // JUMPL not
        vecs.push_back(mk(5'd11, 16'd7,     16'd7,  16'd0,  7'd1,   16'd0,  1'b0, 16'd0,  3'b100)); // CMP eq
        vecs.push_back(mk(5'd9,  16'd0,     16'd0,  16'd0,  7'd1,   16'd0,  1'b0, 16'd1,  3'b100)); // JUMPE taken
        vecs.push_back(mk(5'd10, 16'd0,     16'd0,  16'd3,  7'd1,   16'd0,  1'b0, 16'd3,  3'b100)); // JUMPNE not
        vecs.push_back(mk(5'd2,  16'd1,     16'd2,  16'd0,  7'd0,   16'd3,  1'b1, 16'd0,  3'b100)); // ADD keeps flags
        vecs.push_back(mk(5'd9,  16'd0,     16'd0,  16'd0,  7'd1,   16'd0,  1'b0, 16'd1,  3'b100)); // JUMPE still taken
        vecs.push_back(mk(5'd12, 16'd8,     16'd0,  16'd0,  7'd1,   16'd9,  1'b1, 16'd0,  3'b100)); // LOAD
        vecs.push_back(mk(5'd13, 16'd100,   16'd0,  16'd0,  7'd31,  16'd31, 1'b1, 16'd0,  3'b100)); // LOADI
        vecs.push_back(mk(5'd14, 16'd16,    16'd5,  16'd0,  7'd31,  16'd47, 1'b0, 16'd0,  3'b100)); // STORE
        vecs.push_back(mk(5'd15, 16'd3,     16'd11, 16'd0,  7'd0,   16'd11, 1'b1, 16'd0,  3'b100)); // MOV
        vecs.push_back(mk(5'd6,  16'd0,     16'd0,  16'd10, 7'h7E,  16'd0,  1'b0, 16'd8,  3'b100)); // JUMP back 2
        vecs.push_back(mk(5'h12, 16'd1,     16'd2,  16'd4,  7'd0,   16'd0,  1'b0, 16'd4,  3'b100)); // reserved ADD
        vecs.push_back(mk(5'h16, 16'd0,     16'd0,  16'd4,  7'd1,   16'd0,  1'b0, 16'd4,  3'b100)); // reserved JUMP
        vecs.push_back(mk(5'h1B, 16'd1,     16'd9,  16'd0,  7'd0,   16'd0,  1'b0, 16'd0,  3'b100)); // reserved CMP

        // Reset with nonzero inputs clears everything.
        reset = 1'b1;
        drive(5'd2, 16'h1234, 16'h5678, 16'h0042, 7'h11, 5'd9);
        tick();
        chk_out("reset", 5'd0, 5'd0, 16'd0, 16'd0, 1'b0, 16'd0, 3'b000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [4:0] dest;
            dest = 5'((i * 3 + 1) % 32);
            drive(vecs[i].ctrl, vecs[i].r1, vecs[i].r2, vecs[i].npc, vecs[i].imm, dest);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ctrl, dest, vecs[i].r2,
                    vecs[i].res, vecs[i].we, vecs[i].tgt, vecs[i].flg);
        end

        // Reset mid-sequence drops the in-flight instruction and the flags.
        drive(5'd11, 16'd7, 16'd7, 16'd0, 7'd1, 5'd1);
        tick();
        chk("pre_reset.ZF", 16'(bus.ZF), 16'd1);
        reset = 1'b1;
        drive(5'd2, 16'd1, 16'd1, 16'd20, 7'd1, 5'd3);
        tick();
        chk_out("mid_reset", 5'd0, 5'd0, 16'd0, 16'd0, 1'b0, 16'd0, 3'b000);
        reset = 1'b0;

        // With cleared flags only JUMPNE is taken among the conditional jumps.
        drive(5'd9, 16'd0, 16'd0, 16'd0, 7'd1, 5'd0);
        tick();
        chk("post_reset.JUMPE", bus.target, 16'd0);
        drive(5'd10, 16'd0, 16'd0, 16'd0, 7'd1, 5'd0);
        tick();
        chk("post_reset.JUMPNE", bus.target, 16'd1);
        drive(5'd7, 16'd0, 16'd0, 16'd0, 7'd1, 5'd0);
        tick();
        chk("post_reset.JUMPL", bus.target, 16'd0);
        drive(5'd8, 16'd0, 16'd0, 16'd0, 7'd1, 5'd0);
        tick();
        chk("post_reset.JUMPG", bus.target, 16'd0);

        // CMP then JUMPL back-to-back with a nonzero npc.
        drive(5'd11, 16'h0001, 16'hFFFF, 16'd0, 7'd0, 5'd0);
        tick();
        chk("cmp_unsigned.flags", 16'({bus.ZF, bus.GF, bus.LF}), 16'(3'b001));
        drive(5'd7, 16'd0, 16'd0, 16'd100, 7'd5, 5'd0);
        tick();
        chk("cmp_unsigned.JUMPL", bus.target, 16'd105);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
